// File: rtl/stopwatch_if.sv
// stopwatch_if: button levels and datapath status in, one-cycle datapath commands and status out
interface stopwatch_if;
   logic       start, stop, clr, dir, at_zero, at_max;
   logic       cnt_en, cnt_up, clear_o, load_max, running, done;
   logic [1:0] state_o;
   modport master (
      input  start, stop, clr, dir, at_zero, at_max,
      output cnt_en, cnt_up, clear_o, load_max, running, done, state_o
   );
   modport slave (
      output start, stop, clr, dir, at_zero, at_max,
      input  cnt_en, cnt_up, clear_o, load_max, running, done, state_o
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button edge detection, run/pause/done FSM and 0.1 s timebase for the BCD counter chain
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 10000,
   parameter int unsigned PW       = 14
) (
   input logic         clk,
   input logic         rst,
   stopwatch_if.master sw
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t        state;
   logic [PW-1:0] presc;
   logic          start_q, stop_q, clr_q;
   logic          start_p, stop_p, clr_p, wrap, terminal;
   assign start_p  = sw.start & ~start_q;
   assign stop_p   = sw.stop & ~stop_q;
   assign clr_p    = sw.clr & ~clr_q;
   assign wrap     = presc == PW'(TICK_DIV - 1);
   assign terminal = sw.cnt_up ? sw.at_max : sw.at_zero;
   assign sw.state_o = state;
   assign sw.running = state == RUN;
   assign sw.done    = state == DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         clr_q       <= 1'b0;
         sw.cnt_up   <= 1'b1;
         sw.cnt_en   <= 1'b0;
         sw.clear_o  <= 1'b0;
         sw.load_max <= 1'b0;
      end else begin
         start_q     <= sw.start;
         stop_q      <= sw.stop;
         clr_q       <= sw.clr;
         sw.cnt_en   <= 1'b0;
         sw.clear_o  <= 1'b0;
         sw.load_max <= 1'b0;
         if (clr_p) begin
            state      <= IDLE;
            presc      <= '0;
            sw.clear_o <= 1'b1;
         end else begin
            case (state)
               IDLE: if (start_p) begin
                  state       <= RUN;
                  presc       <= '0;
                  sw.cnt_up   <= sw.dir;
                  sw.clear_o  <= sw.dir & sw.at_max;
                  sw.load_max <= ~sw.dir & sw.at_zero;
               end
               // the edge that leaves RUN on a stop still advances the prescaler
               RUN: begin
                  presc     <= wrap ? '0 : presc + 1'b1;
                  sw.cnt_en <= wrap & ~terminal;
                  if (stop_p) state <= PAUSE;
                  else if (wrap && terminal) state <= DONE;
               end
               PAUSE: if (start_p) state <= RUN;
               DONE: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table plus scripted sequences, expected outputs queued at drive time and checked after each edge
module tb_stopwatch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   stopwatch_if sw();
   stopwatch_ctrl #(.TICK_DIV(10), .PW(4)) dut (.clk(clk), .rst(rst), .sw(sw));
   always #5 clk = ~clk;

   typedef struct {logic [7:0] exp; string name;} sb_t;
   typedef struct {logic s, p, c, d, z, m; logic [7:0] exp;} vec_t;
   sb_t  sb[$];
   vec_t tbl[14];

   function automatic logic [7:0] ex(input logic en, up, cl, ld, input logic [1:0] st);
      return {en, up, cl, ld, st == 2'd1, st == 2'd3, st};
   endfunction

   function automatic logic [7:0] outs();
      return {sw.cnt_en, sw.cnt_up, sw.clear_o, sw.load_max, sw.running, sw.done, sw.state_o};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got en,up,clr,ld,run,done,st=%b required %b", nm, act, exp);
      end
   endtask

   task automatic step(input logic s, p, c, d, z, m, input logic [7:0] e, input string nm);
      sb_t x;
      @(negedge clk);
      sw.start = s; sw.stop = p; sw.clr = c; sw.dir = d; sw.at_zero = z; sw.at_max = m;
      sb.push_back('{e, nm});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk(x.name, outs(), x.exp);
   endtask

   initial begin
      tbl[0]  = '{0, 0, 0, 0, 0, 0, ex(0, 1, 0, 0, 0)};
      tbl[1]  = '{1, 0, 0, 0, 1, 0, ex(0, 0, 0, 1, 1)};
      tbl[2]  = '{1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1)};
      tbl[3]  = '{0, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 2)};
      tbl[4]  = '{1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1)};
      tbl[5]  = '{0, 0, 1, 0, 0, 0, ex(0, 0, 1, 0, 0)};
      tbl[6]  = '{0, 0, 1, 0, 0, 0, ex(0, 0, 0, 0, 0)};
      tbl[7]  = '{1, 0, 0, 1, 0, 1, ex(0, 1, 1, 0, 1)};
      tbl[8]  = '{0, 0, 0, 1, 0, 1, ex(0, 1, 0, 0, 1)};
      tbl[9]  = '{1, 1, 1, 1, 0, 0, ex(0, 1, 1, 0, 0)};
      tbl[10] = '{0, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 0)};
      tbl[11] = '{0, 1, 0, 1, 0, 0, ex(0, 1, 0, 0, 0)};
      tbl[12] = '{1, 1, 1, 0, 1, 0, ex(0, 1, 1, 0, 0)};
      tbl[13] = '{0, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 0)};
      sw.start = 0; sw.stop = 0; sw.clr = 0; sw.dir = 1; sw.at_zero = 0; sw.at_max = 0;
      repeat (2) @(posedge clk);
      #1 chk("reset_state", outs(), ex(0, 1, 0, 0, 0));
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 14; i++)
         step(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].d, tbl[i].z, tbl[i].m, tbl[i].exp, $sformatf("tbl[%0d]", i));
      // count up, three ticks, pause 4 cycles after the third
      step(1, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 1), "up_entry");
      for (int k = 1; k <= 33; k++)
         step(0, 0, 0, 1, 0, 0, ex(k % 10 == 0, 1, 0, 0, 1), $sformatf("up_k%0d", k));
      step(0, 1, 0, 1, 0, 0, ex(0, 1, 0, 0, 2), "pause_enter");
      for (int k = 0; k < 50; k++)
         step(0, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 2), $sformatf("pause_k%0d", k));
      step(1, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 1), "resume");
      for (int k = 1; k <= 16; k++)
         step(0, 0, 0, 1, 0, 0, ex(k == 6 || k == 16, 1, 0, 0, 1), $sformatf("resume_k%0d", k));
      for (int k = 17; k <= 26; k++)
         step(0, 0, 0, 1, 0, 1, ex(0, 1, 0, 0, k == 26 ? 2'd3 : 2'd1), $sformatf("max_k%0d", k));
      step(1, 0, 0, 1, 0, 1, ex(0, 1, 0, 0, 3), "done_start_ignored");
      step(0, 0, 1, 1, 0, 1, ex(0, 1, 1, 0, 0), "done_clr");
      step(0, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 0), "done_clr_after");
      // count down from zero
      step(1, 0, 0, 0, 1, 0, ex(0, 0, 0, 1, 1), "down_entry");
      for (int k = 1; k <= 30; k++)
         step(0, 0, 0, 0, k == 30, 0, ex(k % 10 == 0 && k < 30, 0, 0, 0, k == 30 ? 2'd3 : 2'd1), $sformatf("down_k%0d", k));
      step(0, 0, 1, 0, 0, 0, ex(0, 0, 1, 0, 0), "down_clr");
      step(0, 0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0), "down_clr_after");
      // held start must enter RUN only once, so ticks stay on a 10-cycle grid
      for (int k = 0; k <= 100; k++)
         step(1, 0, 0, 1, 0, 0, ex(k > 0 && k % 10 == 0, 1, 0, 0, 1), $sformatf("hold_k%0d", k));
      #2 rst = 1'b1;
      sw.start = 0;
      #1 chk("async_reset", outs(), ex(0, 1, 0, 0, 0));
      @(negedge clk) rst = 1'b0;
      step(1, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 1), "post_reset_entry");
      for (int k = 1; k <= 10; k++)
         step(0, 0, 0, 1, 0, 0, ex(k == 10, 1, 0, 0, 1), $sformatf("post_reset_k%0d", k));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
